// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O hub.
package board_io_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PWM_W       = 8;

  // Counter width that can hold DEBOUNCE_CYCLES-1.
  function automatic int unsigned deb_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-bit 2-FF synchroniser followed by a counter-based debouncer for a W-bit vector.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned W               = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic         clk_i,
  input  logic         srst_ni,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] lvl_o
);

  localparam int unsigned CW = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  typedef struct packed {
    logic          lvl;
    logic [CW-1:0] cnt;
  } deb_state_t;

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] s;
  deb_state_t [W-1:0] st_q, st_d;

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      st_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      st_q <= st_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    st_d = st_q;
    for (int unsigned i = 0; i < W; i++) begin
      if (s[i] == st_q[i].lvl) begin
        st_d[i].cnt = '0;
      end else if (st_q[i].cnt == CntMax) begin
        st_d[i].lvl = s[i];
        st_d[i].cnt = '0;
      end else begin
        st_d[i].cnt = st_q[i].cnt + 1'b1;
      end
    end
  end

  always_comb begin
    lvl_o = '0;
    for (int unsigned i = 0; i < W; i++) lvl_o[i] = st_q[i].lvl;
  end

endmodule

// File: rtl/board_io_hub.sv
// Board I/O front end: debounced switches/buttons, sticky maskable button IRQs, LED register.
// Optional LED PWM dimming is enabled by defining BOARD_IO_LED_PWM_EN.
module board_io_hub
  import board_io_pkg::*;
#(
  parameter int unsigned NUM_SW          = 16,
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned NUM_LED         = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk_i,
  input  logic               srst_ni,
  input  logic [NUM_SW-1:0]  sw_pin_i,
  input  logic [NUM_BTN-1:0] btn_pin_i,
  output logic [NUM_SW-1:0]  sw_o,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] irq_pend_o,
  output logic               irq_o,
  input  logic [NUM_BTN-1:0] irq_clr_i,
  input  logic               mask_we_i,
  input  logic [NUM_BTN-1:0] mask_wdata_i,
  input  logic               led_we_i,
  input  logic [NUM_LED-1:0] led_wdata_i,
`ifdef BOARD_IO_LED_PWM_EN
  input  logic [PWM_W-1:0]   led_duty_i,
`endif
  output logic [NUM_LED-1:0] led_o
);

  logic [NUM_BTN-1:0] btn_dly_q, rise;
  logic [NUM_BTN-1:0] pend_q, mask_q;
  logic               irq_q;
  logic [NUM_LED-1:0] led_reg_q;

  io_debounce #(
    .W               (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_deb (
    .clk_i   (clk_i),
    .srst_ni (srst_ni),
    .pin_i   (sw_pin_i),
    .lvl_o   (sw_o)
  );

  io_debounce #(
    .W               (NUM_BTN),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_deb (
    .clk_i   (clk_i),
    .srst_ni (srst_ni),
    .pin_i   (btn_pin_i),
    .lvl_o   (btn_o)
  );

  assign rise = btn_o & ~btn_dly_q;

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      btn_dly_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      led_reg_q <= '0;
    end else begin
      btn_dly_q <= btn_o;
      // Set after clear so a same-cycle rise wins.
      pend_q    <= (pend_q & ~irq_clr_i) | rise;
      if (mask_we_i) mask_q <= mask_wdata_i;
      irq_q     <= |(pend_q & mask_q);
      if (led_we_i) led_reg_q <= led_wdata_i;
    end
  end

  assign irq_pend_o = pend_q;
  assign irq_o      = irq_q;

`ifdef BOARD_IO_LED_PWM_EN
  logic [PWM_W-1:0]   pwm_cnt_q, duty_q;
  logic [NUM_LED-1:0] led_q;
  logic               pwm_on;

  assign pwm_on = pwm_cnt_q < duty_q;

  // Duty is only reloaded at the period boundary to avoid mid-period glitches.
  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (pwm_cnt_q == {PWM_W{1'b1}}) duty_q <= led_duty_i;
      led_q     <= led_reg_q & {NUM_LED{pwm_on}};
    end
  end

  assign led_o = led_q;
`else
  assign led_o = led_reg_q;
`endif

endmodule
